// File: rtl/conv_seq_ctrl_pkg.sv
// Shared types and constants for the CONV sequencing controller.
package conv_pkg;
  typedef enum logic [2:0] {IDLE, C_CLR, C_TAP, C_WR, P_CLR, P_RD, P_WR, DONE} state_t;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  localparam int TAPS     = 9;
  localparam int POOL_RDS = 4;

  // Row-major 3x3 neighbourhood offsets
  localparam logic signed [1:0] TAP_DY [TAPS] =
    '{2'sb11, 2'sb11, 2'sb11, 2'sb00, 2'sb00, 2'sb00, 2'sb01, 2'sb01, 2'sb01};
  localparam logic signed [1:0] TAP_DX [TAPS] =
    '{2'sb11, 2'sb00, 2'sb01, 2'sb11, 2'sb00, 2'sb01, 2'sb11, 2'sb00, 2'sb01};

  typedef struct packed {
    logic       busy;
    logic       mac_clr;
    logic       mac_en;
    logic [3:0] mac_tap;
    logic       mac_pad;
    logic       pool_clr;
    logic       pool_en;
    logic       cwr;
    logic       crd;
    logic [2:0] csel;
  } ctrl_t;

  function automatic logic signed [1:0] tap_dy(input logic [3:0] t);
    return (t < 4'(TAPS)) ? TAP_DY[t] : 2'sb00;
  endfunction

  function automatic logic signed [1:0] tap_dx(input logic [3:0] t);
    return (t < 4'(TAPS)) ? TAP_DX[t] : 2'sb00;
  endfunction
endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Controller-to-datapath/memory bus for the CONV engine.
interface conv_seq_ctrl_if #(parameter int ADDR_W = 12);
  logic              ready;
  logic              busy;
  logic [ADDR_W-1:0] iaddr;
  logic              mac_clr;
  logic              mac_en;
  logic [3:0]        mac_tap;
  logic              mac_pad;
  logic              pool_clr;
  logic              pool_en;
  logic              cwr;
  logic [ADDR_W-1:0] caddr_wr;
  logic              crd;
  logic [ADDR_W-1:0] caddr_rd;
  logic [2:0]        csel;

  modport master (
    input  ready,
    output busy, iaddr, mac_clr, mac_en, mac_tap, mac_pad, pool_clr, pool_en,
           cwr, caddr_wr, crd, caddr_rd, csel
  );

  modport slave (
    output ready,
    input  busy, iaddr, mac_clr, mac_en, mac_tap, mac_pad, pool_clr, pool_en,
           cwr, caddr_wr, crd, caddr_rd, csel
  );
endinterface

// File: rtl/conv_tap_addr.sv
// Neighbour address + pad flag for a 3x3 tap, or a 2x2 pool window offset.
module conv_tap_addr
  import conv_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int ADDR_W = 12,
  parameter int LW     = $clog2(IMG_W)
) (
  input  logic [LW-1:0]     row,
  input  logic [LW-1:0]     col,
  input  logic [3:0]        tap,
  input  logic              pool,
  output logic [ADDR_W-1:0] addr,
  output logic              pad
);
  logic signed [1:0] dy, dx;
  logic [LW+1:0]     rr, cc;

  always_comb begin
    dy = pool ? {1'b0, tap[1]} : tap_dy(tap);
    dx = pool ? {1'b0, tap[0]} : tap_dx(tap);
    rr = {2'b00, row} + {{LW{dy[1]}}, dy};
    cc = {2'b00, col} + {{LW{dx[1]}}, dx};
    // Two guard bits: 11 means -1, 01 means IMG_W; either is off-image
    pad  = (rr[LW+1:LW] != 2'b00) || (cc[LW+1:LW] != 2'b00);
    addr = pad ? ADDR_W'({row, col}) : ADDR_W'({rr[LW-1:0], cc[LW-1:0]});
  end
endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer for the CONV engine: 3x3 conv+ReLU into L0, then 2x2 max-pool into L1.
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int ADDR_W = 12
) (
  input  logic           clk,
  input  logic           reset,
  conv_seq_ctrl_if.master bus
);
  localparam int LW = $clog2(IMG_W);
  localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(IMG_W*IMG_W - 1);
  localparam logic [ADDR_W-1:0] POOL_LAST = ADDR_W'(IMG_W*IMG_W/4 - 1);

  state_t            st, st_n;
  logic [ADDR_W-1:0] pix, pix_n, pidx, pidx_n;
  logic [3:0]        tap, tap_n;
  logic [1:0]        rd, rd_n;

  ctrl_t             ctrl, ctrl_n;
  logic [ADDR_W-1:0] iaddr, iaddr_n, caddr_wr, caddr_wr_n, caddr_rd, caddr_rd_n;

  logic              pool_mode;
  logic [LW-1:0]     ta_row, ta_col;
  logic [3:0]        ta_tap;
  logic [ADDR_W-1:0] ta_addr;
  logic              ta_pad;

  always_comb begin
    st_n   = st;
    pix_n  = pix;
    pidx_n = pidx;
    tap_n  = tap;
    rd_n   = rd;
    case (st)
      IDLE:  if (bus.ready) begin st_n = C_CLR; pix_n = '0; end
      C_CLR: begin st_n = C_TAP; tap_n = '0; end
      C_TAP: if (tap == 4'(TAPS-1)) st_n = C_WR;
             else tap_n = tap + 4'd1;
      C_WR:  if (pix == PIX_LAST) begin st_n = P_CLR; pidx_n = '0; end
             else begin st_n = C_CLR; pix_n = pix + ADDR_W'(1); end
      P_CLR: begin st_n = P_RD; rd_n = '0; end
      P_RD:  if (rd == 2'(POOL_RDS-1)) st_n = P_WR;
             else rd_n = rd + 2'd1;
      P_WR:  if (pidx == POOL_LAST) st_n = DONE;
             else begin st_n = P_CLR; pidx_n = pidx + ADDR_W'(1); end
      DONE:  st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they register on the same edge
  assign pool_mode = (st_n == P_RD);
  assign ta_row = pool_mode ? {pidx_n[2*LW-3:LW-1], 1'b0} : pix_n[2*LW-1:LW];
  assign ta_col = pool_mode ? {pidx_n[LW-2:0], 1'b0}      : pix_n[LW-1:0];
  assign ta_tap = pool_mode ? {2'b00, rd_n}               : tap_n;

  conv_tap_addr #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) u_tap_addr (
    .row  (ta_row),
    .col  (ta_col),
    .tap  (ta_tap),
    .pool (pool_mode),
    .addr (ta_addr),
    .pad  (ta_pad)
  );

  always_comb begin
    ctrl_n      = '0;
    ctrl_n.csel = CSEL_NONE;
    iaddr_n     = '0;
    caddr_wr_n  = '0;
    caddr_rd_n  = '0;
    ctrl_n.busy = !(st_n inside {IDLE, DONE});
    case (st_n)
      C_CLR: ctrl_n.mac_clr = 1'b1;
      C_TAP: begin
        ctrl_n.mac_en  = 1'b1;
        ctrl_n.mac_tap = tap_n;
        ctrl_n.mac_pad = ta_pad;
        iaddr_n        = ta_addr;
      end
      C_WR: begin
        ctrl_n.cwr  = 1'b1;
        ctrl_n.csel = CSEL_L0;
        caddr_wr_n  = pix_n;
      end
      P_CLR: ctrl_n.pool_clr = 1'b1;
      P_RD: begin
        ctrl_n.crd     = 1'b1;
        ctrl_n.pool_en = 1'b1;
        ctrl_n.csel    = CSEL_L0;
        caddr_rd_n     = ta_addr;
      end
      P_WR: begin
        ctrl_n.cwr  = 1'b1;
        ctrl_n.csel = CSEL_L1;
        caddr_wr_n  = pidx_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= IDLE;
      pix      <= '0;
      pidx     <= '0;
      tap      <= '0;
      rd       <= '0;
      ctrl     <= '0;
      iaddr    <= '0;
      caddr_wr <= '0;
      caddr_rd <= '0;
    end else begin
      st       <= st_n;
      pix      <= pix_n;
      pidx     <= pidx_n;
      tap      <= tap_n;
      rd       <= rd_n;
      ctrl     <= ctrl_n;
      iaddr    <= iaddr_n;
      caddr_wr <= caddr_wr_n;
      caddr_rd <= caddr_rd_n;
    end
  end

  assign bus.busy     = ctrl.busy;
  assign bus.mac_clr  = ctrl.mac_clr;
  assign bus.mac_en   = ctrl.mac_en;
  assign bus.mac_tap  = ctrl.mac_tap;
  assign bus.mac_pad  = ctrl.mac_pad;
  assign bus.pool_clr = ctrl.pool_clr;
  assign bus.pool_en  = ctrl.pool_en;
  assign bus.cwr      = ctrl.cwr;
  assign bus.crd      = ctrl.crd;
  assign bus.csel     = ctrl.csel;
  assign bus.iaddr    = iaddr;
  assign bus.caddr_wr = caddr_wr;
  assign bus.caddr_rd = caddr_rd;
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Cycle-level check of conv_seq_ctrl against an offset-based schedule model.
module tb_conv_seq_ctrl;
  localparam int IMG_W    = 64;
  localparam int ADDR_W   = 12;
  localparam int NPIX     = IMG_W*IMG_W;
  localparam int NPOOL    = NPIX/4;
  localparam int CONV_CYC = NPIX*11;
  localparam int RUN_CYC  = CONV_CYC + NPOOL*6;
  localparam int PX_LAST  = (NPIX-1)*11;
  localparam int POOL33   = CONV_CYC + 33*6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  conv_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus();
  conv_seq_ctrl #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic busy, mac_clr, mac_en, mac_pad, pool_clr, pool_en, cwr, crd;
    logic [3:0] mac_tap;
    logic [2:0] csel;
    int iaddr, caddr_wr, caddr_rd;
  } exp_t;

  // Schedule model: a run is a fixed timeline, offset 0 = first conv cycle, RUN_CYC = DONE
  bit m_run = 1'b0;
  int m_off = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run <= 1'b0;
      m_off <= 0;
    end else if (m_run) begin
      if (m_off == RUN_CYC) m_run <= 1'b0;
      else m_off <= m_off + 1;
    end else if (bus.ready) begin
      m_run <= 1'b1;
      m_off <= 0;
    end
  end

  function automatic exp_t model(input bit run, input int o);
    exp_t e;
    e = '{default: 0};
    if (run && o < CONV_CYC) begin
      int p, s, r, c;
      p = o / 11; s = o % 11; r = p / IMG_W; c = p % IMG_W;
      e.busy = 1'b1;
      if (s == 0) e.mac_clr = 1'b1;
      else if (s == 10) begin e.cwr = 1'b1; e.csel = 3'b001; e.caddr_wr = p; end
      else begin
        int t, rr, cc;
        t = s - 1; rr = r + t/3 - 1; cc = c + t%3 - 1;
        e.mac_en  = 1'b1;
        e.mac_tap = 4'(t);
        e.mac_pad = (rr < 0 || rr >= IMG_W || cc < 0 || cc >= IMG_W);
        e.iaddr   = e.mac_pad ? p : rr*IMG_W + cc;
      end
    end else if (run && o < RUN_CYC) begin
      int q, k, s, pr, pc;
      q = o - CONV_CYC; k = q / 6; s = q % 6; pr = k / (IMG_W/2); pc = k % (IMG_W/2);
      e.busy = 1'b1;
      if (s == 0) e.pool_clr = 1'b1;
      else if (s == 5) begin e.cwr = 1'b1; e.csel = 3'b011; e.caddr_wr = k; end
      else begin
        int j;
        j = s - 1;
        e.crd = 1'b1; e.pool_en = 1'b1; e.csel = 3'b001;
        e.caddr_rd = (2*pr + j/2)*IMG_W + 2*pc + j%2;
      end
    end
    return e;
  endfunction

  int n_vec = 0;
  int n_err = 0;
  int busy_cnt = 0, l0_cnt = 0, l1_cnt = 0;
  bit tmo = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t off=%0d act=%0d exp=%0d", name, $time, m_off, act, exp);
    end
  endtask

  // Single compare process, sampling mid-cycle and just after reset assertion
  initial begin
    exp_t e;
    logic [8:0] pad0, pad_last;
    int rd33 [4];
    pad0 = 9'b001001111;
    pad_last = 9'b111100100;
    rd33 = '{130, 131, 194, 195};
    forever begin
      @(negedge clk or negedge reset);
      #1;
      e = model(m_run, m_off);
      chk("strobes",
          {bus.busy, bus.mac_clr, bus.mac_en, bus.pool_clr, bus.pool_en, bus.cwr, bus.crd, bus.csel},
          {e.busy, e.mac_clr, e.mac_en, e.pool_clr, e.pool_en, e.cwr, e.crd, e.csel});
      if (e.mac_en) begin
        chk("mac_tap", bus.mac_tap, e.mac_tap);
        chk("mac_pad", bus.mac_pad, e.mac_pad);
        chk("iaddr", bus.iaddr, e.iaddr);
      end
      if (e.cwr) chk("caddr_wr", bus.caddr_wr, e.caddr_wr);
      if (e.crd) chk("caddr_rd", bus.caddr_rd, e.caddr_rd);
      if (tmo) chk("timeout", tmo, 0);

      if (!reset) begin
        chk("rst_addr", {bus.iaddr, bus.caddr_wr, bus.caddr_rd}, 0);
        chk("rst_tap", {bus.mac_tap, bus.mac_pad}, 0);
        busy_cnt = 0; l0_cnt = 0; l1_cnt = 0;
      end else begin
        busy_cnt += int'(bus.busy);
        if (bus.cwr && bus.csel == 3'b001) l0_cnt++;
        if (bus.cwr && bus.csel == 3'b011) l1_cnt++;
      end

      if (m_run && reset) begin
        if (m_off >= 1 && m_off <= 9) chk("px0_pad", bus.mac_pad, pad0[m_off-1]);
        if (m_off == 9)  chk("px0_tap8_iaddr", bus.iaddr, 65);
        if (m_off == 10) chk("px0_wr", {bus.cwr, bus.csel, bus.caddr_wr}, {1'b1, 3'b001, 12'd0});
        if (m_off >= PX_LAST+1 && m_off <= PX_LAST+9)
          chk("pxl_pad", bus.mac_pad, pad_last[m_off-PX_LAST-1]);
        if (m_off == PX_LAST+1) chk("pxl_tap0_iaddr", bus.iaddr, 4030);
        if (m_off == CONV_CYC)  chk("pxl_next_pclr", {bus.pool_clr, bus.crd}, 2'b10);
        if (m_off >= POOL33+1 && m_off <= POOL33+4)
          chk("pool33_rd", bus.caddr_rd, rd33[m_off-POOL33-1]);
        if (m_off == POOL33+5) chk("pool33_wr", {bus.cwr, bus.csel, bus.caddr_wr}, {1'b1, 3'b011, 12'd33});
        if (m_off == RUN_CYC) begin
          chk("busy_cycles", busy_cnt, RUN_CYC);
          chk("l0_writes", l0_cnt, NPIX);
          chk("l1_writes", l1_cnt, NPOOL);
        end
      end
    end
  end

  task automatic finish_up();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  task automatic wait_off(input int target);
    for (int i = 0; i < RUN_CYC + 100 && !(m_run && m_off == target); i++) @(negedge clk);
    if (!(m_run && m_off == target)) begin
      tmo = 1'b1;
      repeat (2) @(negedge clk);
      finish_up();
    end
  endtask

  initial begin
    bus.ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); bus.ready = 1'b1;
    @(negedge clk); bus.ready = 1'b0;
    // Reset in the middle of pixel 100, tap 4
    wait_off(1105);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    // Full run, with a stray ready pulse while busy
    bus.ready = 1'b1;
    @(negedge clk); bus.ready = 1'b0;
    wait_off(20000);
    bus.ready = 1'b1;
    @(negedge clk); bus.ready = 1'b0;
    // Hold ready through DONE so a second run starts from IDLE
    wait_off(RUN_CYC - 5);
    bus.ready = 1'b1;
    wait_off(RUN_CYC);
    repeat (16) @(negedge clk);
    finish_up();
  end
endmodule
